sumatoria_seq: RTL and testbench
================================

# sumatoria_seq

Frame sequencer for the thermometer-sum datapath. It collects one OSF-bit thermometer word per sample from the comparator front end into a SAMPLES×OSF frame buffer. It then drives the summation block's Input and Enable for a programmable settle window and captures the binary sum into a result register. The captured result is handed downstream over a valid/ready handshake. It sits between the comparator sampler and the summation block and is the only block allowed to drive that block's Enable.

## Interface
Parameters:
- SAMPLES, 128, thermometer words per frame (≥2)
- OSF, 8, bits per word; the summation block supports only 8
- SETTLE, 4, cycles Sum_Enable is held before capture (≥1); covers the combinational adder-tree delay
- RW (localparam) = $clog2(SAMPLES*OSF)+1, result width (11 at defaults)

Ports:
- Clk  in  1  rising-edge clock, single domain
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  begin a frame; honoured in IDLE only
- Abort  in  1  synchronous return to IDLE, no result produced
- Sample_In  in  OSF  thermometer word
- Sample_Valid  in  1  Sample_In qualifier, one word per cycle
- Sum_Input  out  SAMPLES*OSF  frame buffer, to summation Input
- Sum_Enable  out  1  to summation Enable
- Sum_Output  in  RW  from summation Output
- Result  out  RW  captured frame sum
- Result_Valid  out  1  Result available
- Result_Ready  in  1  downstream accept
- Busy  out  1  high in any state other than IDLE
- Overrun  out  1  sticky; a sample arrived while it could not be stored
- Thermo_Err  out  1  sticky; a non-thermometer word was accepted (see Configuration)

## Operation
- States: IDLE, FILL, SUM, HOLD. Reset and Abort both force IDLE.
- Reset values: state IDLE, frame buffer 0, slot counter 0, settle counter 0. All outputs are 0.
- IDLE:
  - Start=1 → FILL, slot counter 0, Overrun and Thermo_Err cleared.
  - Sample_Valid is ignored and does not flag.
- FILL:
  - Each Sample_Valid writes Sample_In into Sum_Input[OSF*k +: OSF], k = slot counter. Slot 0 is the LSB word. The counter then increments.
  - The write with k=SAMPLES-1 → SUM, settle counter 0.
  - Start is ignored. The buffer is not cleared between frames; every slot is overwritten.
- SUM:
  - Sum_Enable=1 for exactly SETTLE cycles.
  - On the cycle with settle counter = SETTLE-1: Result ← Sum_Output, go to HOLD.
- HOLD:
  - Sum_Enable=0, Result_Valid=1.
  - Result_Valid && Result_Ready → IDLE, Result_Valid=0 next cycle.
  - Result holds its value until the next capture.
- Sample_Valid in SUM or HOLD: the word is discarded, the buffer is unchanged, and Overrun is set.
- Abort=1 in any state → IDLE next cycle.
  - Result_Valid=0, Sum_Enable=0.
  - Result, buffer and sticky flags are retained.
  - Abort beats Start, Sample_Valid and Result_Ready in the same cycle.
- Start in the same cycle as the HOLD handshake is ignored. A new Start is needed from IDLE.
- Arithmetic:
  - Sums are unsigned.
  - The maximum SAMPLES*OSF fits in RW bits, so there is no saturation.
  - Result is an RW-bit register, with no truncation.

## Timing
- Start edge → FILL on the next cycle. The first sample is accepted in the cycle after Start at the earliest.
- The last-sample edge E0 → Sum_Enable high during cycles E0+1 … E0+SETTLE.
- Result_Valid rises at edge E0+SETTLE and is visible in cycle E0+SETTLE+1 (SETTLE cycles after the last sample).
- Minimum frame period: 1 (Start) + SAMPLES + SETTLE + 1 (handshake) cycles.
- Busy is registered, high from the cycle after Start until the cycle after the handshake or Abort.
- Reset_n low is sampled on an edge and overrides every input, including mid-FILL and mid-SUM.

## Configuration
- SUMATORIA_SEQ_THERMO_CHECK_EN defined:
  - Each word accepted in FILL is checked for the thermometer form (2^n−1, n=0…OSF; ones contiguous from bit 0).
  - A failing word is still stored, and Thermo_Err is set (sticky, cleared on Start or reset).
- Undefined: the check logic is absent and Thermo_Err is tied to 0.

## Test plan
- SAMPLES=4, OSF=8, SETTLE=2; Start, then words 0x01, 0x03, 0x0F, 0xFF on consecutive cycles, with the bench's summation model attached → Sum_Enable high 2 cycles, Result=15, Result_Valid 2 cycles after the last sample; Ready=1 → IDLE, Busy=0.
- Defaults; all 128 words 0xFF → Result=1024, no overflow in 11 bits. All words 0x00 → Result=0.
- Ready held low 10 cycles in HOLD while Sample_Valid pulses → Result stable, Result_Valid held, Overrun=1 and buffer unchanged. The next Start clears Overrun.
- Abort after 2 of 4 samples → IDLE next cycle, no Result_Valid, Sum_Enable never asserted. A new frame 0x07×4 → Result=12.
- Reset_n low during SUM → all outputs 0 the next cycle. Start with Abort in the same cycle → stays IDLE.
- With SUMATORIA_SEQ_THERMO_CHECK_EN, word 0x05 → Thermo_Err=1 and the frame still completes. Without the macro → Thermo_Err=0.

Source files
------------

// File: rtl/sumatoria_seq.sv
// Frame sequencer for the thermometer-sum datapath: fills a SAMPLES x OSF frame buffer,
// enables the summation block for SETTLE cycles, then captures and hands off the sum.
// Optional thermometer-form check on accepted words: define SUMATORIA_SEQ_THERMO_CHECK_EN.
module sumatoria_seq #(
   parameter int SAMPLES = 128,
   parameter int OSF     = 8,
   parameter int SETTLE  = 4,
   localparam int RW     = $clog2(SAMPLES*OSF) + 1
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   Start,
   input  logic                   Abort,
   input  logic [OSF-1:0]         Sample_In,
   input  logic                   Sample_Valid,
   output logic [SAMPLES*OSF-1:0] Sum_Input,
   output logic                   Sum_Enable,
   input  logic [RW-1:0]          Sum_Output,
   output logic [RW-1:0]          Result,
   output logic                   Result_Valid,
   input  logic                   Result_Ready,
   output logic                   Busy,
   output logic                   Overrun,
   output logic                   Thermo_Err
);

   localparam int SW = $clog2(SAMPLES);
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_SUM, S_HOLD} state_t;

   state_t                 state_q, state_d;
   logic [SAMPLES*OSF-1:0] buf_q, buf_d;
   logic [SW-1:0]          slot_q, slot_d;
   logic [CW-1:0]          settle_q, settle_d;
   logic [RW-1:0]          result_q, result_d;
   logic                   overrun_q, overrun_d;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
   logic                   thermo_err_q, thermo_err_d;
`endif

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latch).
      state_d      = state_q;
      buf_d        = buf_q;
      slot_d       = slot_q;
      settle_d     = settle_q;
      result_d     = result_q;
      overrun_d    = overrun_q;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
      thermo_err_d = thermo_err_q;
`endif
      // Abort wins over every other input and leaves result, buffer and flags untouched.
      if (Abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (Start) begin
                  state_d      = S_FILL;
                  slot_d       = '0;
                  overrun_d    = 1'b0;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
                  thermo_err_d = 1'b0;
`endif
               end
            end
            S_FILL: begin
               if (Sample_Valid) begin
                  buf_d[OSF*slot_q +: OSF] = Sample_In;
                  slot_d                   = slot_q + SW'(1);
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
                  // 2^n-1 has no set bit in common with its successor.
                  if ((Sample_In & (Sample_In + OSF'(1))) != '0) thermo_err_d = 1'b1;
`endif
                  if (slot_q == SW'(SAMPLES-1)) begin
                     state_d  = S_SUM;
                     settle_d = '0;
                  end
               end
            end
            S_SUM: begin
               if (Sample_Valid) overrun_d = 1'b1;
               if (settle_q == CW'(SETTLE-1)) begin
                  result_d = Sum_Output;
                  state_d  = S_HOLD;
               end else begin
                  settle_d = settle_q + CW'(1);
               end
            end
            S_HOLD: begin
               if (Sample_Valid) overrun_d = 1'b1;
               if (Result_Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         buf_q        <= '0;
         slot_q       <= '0;
         settle_q     <= '0;
         result_q     <= '0;
         overrun_q    <= 1'b0;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
         thermo_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         slot_q       <= slot_d;
         settle_q     <= settle_d;
         result_q     <= result_d;
         overrun_q    <= overrun_d;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
         thermo_err_q <= thermo_err_d;
`endif
      end
   end

   assign Sum_Input    = buf_q;
   assign Sum_Enable   = (state_q == S_SUM);
   assign Result_Valid = (state_q == S_HOLD);
   assign Busy         = (state_q != S_IDLE);
   assign Result       = result_q;
   assign Overrun      = overrun_q;
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
   assign Thermo_Err   = thermo_err_q;
`else
   assign Thermo_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_sumatoria_seq.sv
// Directed bench for sumatoria_seq: a small instance (4x8, settle 2) and a default one (128x8, settle 4),
// each with a popcount summation model that only drives its output while enabled.
module tb_sumatoria_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // small instance
   logic        a_start, a_abort, a_valid, a_ready;
   logic [7:0]  a_in;
   logic [31:0] a_sum_in;
   logic        a_en, a_rv, a_busy, a_ovr, a_terr;
   logic [5:0]  a_sum_out, a_result;

   // default instance
   logic          b_start, b_abort, b_valid, b_ready;
   logic [7:0]    b_in;
   logic [1023:0] b_sum_in;
   logic          b_en, b_rv, b_busy, b_ovr, b_terr;
   logic [10:0]   b_sum_out, b_result;

   int n_total = 0;
   int n_bad   = 0;

   function automatic int popcnt(input logic [1023:0] v);
      int c = 0;
      for (int i = 0; i < 1024; i++) c += int'(v[i]);
      return c;
   endfunction

   always_comb begin
      a_sum_out = '0;
      if (a_en) a_sum_out = 6'(popcnt(1024'(a_sum_in)));
   end

   always_comb begin
      b_sum_out = '0;
      if (b_en) b_sum_out = 11'(popcnt(b_sum_in));
   end

   sumatoria_seq #(.SAMPLES(4), .OSF(8), .SETTLE(2)) u_a (
      .Clk(clk), .Reset_n(rst_n), .Start(a_start), .Abort(a_abort),
      .Sample_In(a_in), .Sample_Valid(a_valid), .Sum_Input(a_sum_in), .Sum_Enable(a_en),
      .Sum_Output(a_sum_out), .Result(a_result), .Result_Valid(a_rv), .Result_Ready(a_ready),
      .Busy(a_busy), .Overrun(a_ovr), .Thermo_Err(a_terr)
   );

   sumatoria_seq u_b (
      .Clk(clk), .Reset_n(rst_n), .Start(b_start), .Abort(b_abort),
      .Sample_In(b_in), .Sample_Valid(b_valid), .Sum_Input(b_sum_in), .Sum_Enable(b_en),
      .Sum_Output(b_sum_out), .Result(b_result), .Result_Valid(b_rv), .Result_Ready(b_ready),
      .Busy(b_busy), .Overrun(b_ovr), .Thermo_Err(b_terr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_frame(input logic [31:0] f);
      for (int i = 0; i < 4; i++) begin
         a_in    = f[8*i +: 8];
         a_valid = 1'b1;
         tick();
      end
      a_valid = 1'b0;
   endtask

   task automatic a_go();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
   endtask

   task automatic a_accept();
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
   endtask

   task automatic b_frame(input logic [7:0] w, input logic [10:0] exp);
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int i = 0; i < 128; i++) begin
         b_in    = w;
         b_valid = 1'b1;
         tick();
      end
      b_valid = 1'b0;
      repeat (3) tick();
      check("b_enable_in_settle", 64'(b_en), 64'd1);
      check("b_valid_early", 64'(b_rv), 64'd0);
      tick();
      check("b_valid", 64'(b_rv), 64'd1);
      check("b_result", 64'(b_result), 64'(exp));
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;
      check("b_idle_after_ack", 64'(b_busy), 64'd0);
   endtask

   logic seen_en;
   logic exp_terr;

   initial begin
      rst_n = 1'b0;
      {a_start, a_abort, a_valid, a_ready, a_in} = '0;
      {b_start, b_abort, b_valid, b_ready, b_in} = '0;
      tick();
      tick();
      rst_n = 1'b1;

      // reset state
      check("rst_busy", 64'(a_busy), 64'd0);
      check("rst_valid", 64'(a_rv), 64'd0);
      check("rst_enable", 64'(a_en), 64'd0);
      check("rst_result", 64'(a_result), 64'd0);
      check("rst_buffer", 64'(a_sum_in), 64'd0);
      check("rst_overrun", 64'(a_ovr), 64'd0);
      check("rst_thermo", 64'(a_terr), 64'd0);
      check("rst_b_busy", 64'(b_busy), 64'd0);

      // basic frame 01,03,0F,FF -> 15
      a_go();
      check("f1_busy", 64'(a_busy), 64'd1);
      check("f1_enable_fill", 64'(a_en), 64'd0);
      a_frame(32'hFF0F0301);
      check("f1_buffer", 64'(a_sum_in), 64'hFF0F0301);
      check("f1_enable_c1", 64'(a_en), 64'd1);
      check("f1_valid_c1", 64'(a_rv), 64'd0);
      tick();
      check("f1_enable_c2", 64'(a_en), 64'd1);
      check("f1_valid_c2", 64'(a_rv), 64'd0);
      tick();
      check("f1_valid", 64'(a_rv), 64'd1);
      check("f1_enable_off", 64'(a_en), 64'd0);
      check("f1_result", 64'(a_result), 64'd15);
      a_accept();
      check("f1_valid_drop", 64'(a_rv), 64'd0);
      check("f1_busy_drop", 64'(a_busy), 64'd0);

      // Sample_Valid in IDLE is ignored silently
      a_in    = 8'hFF;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      check("idle_no_overrun", 64'(a_ovr), 64'd0);
      check("idle_buffer", 64'(a_sum_in), 64'hFF0F0301);

      // HOLD with Ready low and stray samples
      a_go();
      a_frame(32'h01010101);
      tick();
      tick();
      for (int i = 0; i < 10; i++) begin
         a_in    = 8'hFF;
         a_valid = (i % 2 == 0);
         tick();
      end
      a_valid = 1'b0;
      check("hold_valid", 64'(a_rv), 64'd1);
      check("hold_result", 64'(a_result), 64'd4);
      check("hold_overrun", 64'(a_ovr), 64'd1);
      check("hold_buffer", 64'(a_sum_in), 64'h01010101);
      a_start = 1'b1;
      a_accept();
      a_start = 1'b0;
      check("ack_start_ignored", 64'(a_busy), 64'd0);
      check("overrun_sticky", 64'(a_ovr), 64'd1);

      // Start clears Overrun; abort after 2 of 4 samples
      a_go();
      check("start_clears_overrun", 64'(a_ovr), 64'd0);
      a_in    = 8'h3F;
      a_valid = 1'b1;
      tick();
      tick();
      a_valid = 1'b0;
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      check("abort_busy", 64'(a_busy), 64'd0);
      check("abort_valid", 64'(a_rv), 64'd0);
      check("abort_result_kept", 64'(a_result), 64'd4);
      check("abort_buffer_kept", 64'(a_sum_in), 64'h01013F3F);
      seen_en = 1'b0;
      repeat (4) begin
         tick();
         if (a_en || a_rv) seen_en = 1'b1;
      end
      check("abort_no_enable", 64'(seen_en), 64'd0);

      // new frame 07 x4 -> 12
      a_go();
      a_frame(32'h07070707);
      tick();
      tick();
      check("f3_valid", 64'(a_rv), 64'd1);
      check("f3_result", 64'(a_result), 64'd12);
      a_accept();

      // reset during SUM
      a_go();
      a_frame(32'hFFFFFFFF);
      check("sum_enable", 64'(a_en), 64'd1);
      rst_n = 1'b0;
      tick();
      check("rst_sum_busy", 64'(a_busy), 64'd0);
      check("rst_sum_enable", 64'(a_en), 64'd0);
      check("rst_sum_valid", 64'(a_rv), 64'd0);
      check("rst_sum_result", 64'(a_result), 64'd0);
      check("rst_sum_buffer", 64'(a_sum_in), 64'd0);
      rst_n = 1'b1;
      tick();

      // Start with Abort in the same cycle
      a_start = 1'b1;
      a_abort = 1'b1;
      tick();
      a_start = 1'b0;
      a_abort = 1'b0;
      check("start_abort_idle", 64'(a_busy), 64'd0);

      // non-thermometer word 0x05: frame 01,05,03,00 -> 5
`ifdef SUMATORIA_SEQ_THERMO_CHECK_EN
      exp_terr = 1'b1;
`else
      exp_terr = 1'b0;
`endif
      a_go();
      check("thermo_pre", 64'(a_terr), 64'd0);
      a_frame(32'h00030501);
      tick();
      tick();
      check("thermo_flag", 64'(a_terr), 64'(exp_terr));
      check("thermo_valid", 64'(a_rv), 64'd1);
      check("thermo_result", 64'(a_result), 64'd5);
      a_accept();
      check("thermo_sticky", 64'(a_terr), 64'(exp_terr));
      a_go();
      check("thermo_cleared", 64'(a_terr), 64'd0);
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;

      // default geometry: full scale and zero
      b_frame(8'hFF, 11'd1024);
      b_frame(8'h00, 11'd0);
      check("b_no_overrun", 64'(b_ovr), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
